// File: rtl/cursor_ctrl.sv
// cursor_ctrl: edit cursor for the GOL grid editor.
// Four raw active-low direction buttons are synchronised, debounced and turned
// into single-cell steps of an (x,y) cursor with selectable wrap/clamp at the
// grid edges. Defining CURSOR_AUTOREPEAT_EN adds hold-to-auto-repeat; without
// it every press gives exactly one step.
module cursor_ctrl #(
   parameter int unsigned MAX_X        = 32,
   parameter int unsigned MAX_Y        = 32,
   parameter int unsigned XW           = 8,
   parameter int unsigned YW           = 8,
   parameter int unsigned DEBOUNCE_CYC = 4,
   parameter int unsigned REPEAT_DELAY = 16,
   parameter int unsigned REPEAT_RATE  = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [3:0]    move,
   input  logic          wrap_en,
   output logic [XW-1:0] cursor_x,
   output logic [YW-1:0] cursor_y,
   output logic          moved
);

   // Button bit positions within move / step vectors.
   localparam int unsigned BtnXDec = 0;
   localparam int unsigned BtnYInc = 1;
   localparam int unsigned BtnYDec = 2;
   localparam int unsigned BtnXInc = 3;

   // Debounce counter only has to reach DEBOUNCE_CYC-1.
   localparam int unsigned DbW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYC - 1);

   localparam logic [XW-1:0] XLast = XW'(MAX_X - 1);
   localparam logic [YW-1:0] YLast = YW'(MAX_Y - 1);

   // Elaboration-time sanity checks on the configuration.
   if (MAX_X < 1 || ((MAX_X - 1) >> XW) != 0) begin : g_bad_max_x
      $error("cursor_ctrl: MAX_X must be in 1..2**XW");
   end
   if (MAX_Y < 1 || ((MAX_Y - 1) >> YW) != 0) begin : g_bad_max_y
      $error("cursor_ctrl: MAX_Y must be in 1..2**YW");
   end
   if (DEBOUNCE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_timing
      $error("cursor_ctrl: DEBOUNCE_CYC, REPEAT_DELAY and REPEAT_RATE must be >= 1");
   end

   // ---------------------------------------------------------------------------
   // Input synchronisation and debounce
   // ---------------------------------------------------------------------------
   logic [3:0]          sync1_q, sync2_q;
   logic [3:0]          db_q, db_d;
   logic [3:0]          db_prev_q;
   logic [3:0][DbW-1:0] db_cnt_q, db_cnt_d;
   logic [3:0]          press;
   logic [3:0]          step;

   // Two-flop synchroniser; resets to released so a held button reads as a new press.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync1_q <= 4'b1111;
         sync2_q <= 4'b1111;
      end else begin
         sync1_q <= move;
         sync2_q <= sync1_q;
      end
   end

   // Per-bit debounce: accept a change after DEBOUNCE_CYC consecutive mismatches.
   always_comb begin
      db_d     = db_q;
      db_cnt_d = '0;
      for (int i = 0; i < 4; i++) begin
         if (sync2_q[i] != db_q[i]) begin
            if (db_cnt_q[i] == DbLast) begin
               db_d[i] = sync2_q[i];
            end else begin
               db_cnt_d[i] = db_cnt_q[i] + DbW'(1);
            end
         end
      end
   end

   // Debounced state, its previous value (for press detection) and the counters.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         db_q      <= 4'b1111;
         db_prev_q <= 4'b1111;
         db_cnt_q  <= '0;
      end else begin
         db_q      <= db_d;
         db_prev_q <= db_q;
         db_cnt_q  <= db_cnt_d;
      end
   end

   // A press is a debounced 1->0 transition.
   always_comb begin
      press = db_prev_q & ~db_q;
   end

`ifdef CURSOR_AUTOREPEAT_EN
   // ---------------------------------------------------------------------------
   // Auto-repeat FSM
   // ---------------------------------------------------------------------------
   localparam int unsigned RptMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RptW   = (RptMax > 1) ? $clog2(RptMax) : 1;
   localparam logic [RptW-1:0] DelayLoad = RptW'(REPEAT_DELAY - 1);
   localparam logic [RptW-1:0] RateLoad  = RptW'(REPEAT_RATE - 1);

   typedef enum logic [1:0] {StIdle, StHold, StRepeat} state_e;

   state_e          state_q, state_d;
   logic [RptW-1:0] rpt_cnt_q, rpt_cnt_d;
   logic [3:0]      held;

   always_comb begin
      held = ~db_q;
   end

   // State register and repeat counter.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= StIdle;
         rpt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         rpt_cnt_q <= rpt_cnt_d;
      end
   end

   // Next-state logic: full release always wins, a new press re-arms the delay.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (press != '0) state_d = StHold;
         end
         StHold: begin
            if (held == '0) begin
               state_d = StIdle;
            end else if (press == '0 && rpt_cnt_q == '0) begin
               state_d = StRepeat;
            end
         end
         StRepeat: begin
            if (held == '0) begin
               state_d = StIdle;
            end else if (press != '0) begin
               state_d = StHold;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Output logic: step vector and counter reload/decrement.
   always_comb begin
      step      = '0;
      rpt_cnt_d = rpt_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (press != '0) begin
               step      = press;
               rpt_cnt_d = DelayLoad;
            end
         end
         StHold, StRepeat: begin
            if (held != '0) begin
               if (press != '0) begin
                  step      = press;
                  rpt_cnt_d = DelayLoad;
               end else if (rpt_cnt_q == '0) begin
                  // Partial release just shrinks the set of bits that repeat.
                  step      = held;
                  rpt_cnt_d = RateLoad;
               end else begin
                  rpt_cnt_d = rpt_cnt_q - RptW'(1);
               end
            end
         end
         default: begin
            step      = '0;
            rpt_cnt_d = '0;
         end
      endcase
   end
`else
   // One step per press; holding a button does nothing further.
   always_comb begin
      step = press;
   end
`endif

   // ---------------------------------------------------------------------------
   // Cursor arithmetic
   // ---------------------------------------------------------------------------
   logic [XW-1:0] x_q, x_d;
   logic [YW-1:0] y_q, y_d;
   logic          moved_q, moved_d;

   // Opposite directions on one axis cancel; the axes move independently.
   always_comb begin
      x_d = x_q;
      y_d = y_q;
      if (step[BtnXInc] && !step[BtnXDec]) begin
         if (x_q == XLast) x_d = wrap_en ? '0 : XLast;
         else              x_d = x_q + XW'(1);
      end else if (step[BtnXDec] && !step[BtnXInc]) begin
         if (x_q == '0) x_d = wrap_en ? XLast : '0;
         else           x_d = x_q - XW'(1);
      end
      if (step[BtnYInc] && !step[BtnYDec]) begin
         if (y_q == YLast) y_d = wrap_en ? '0 : YLast;
         else              y_d = y_q + YW'(1);
      end else if (step[BtnYDec] && !step[BtnYInc]) begin
         if (y_q == '0) y_d = wrap_en ? YLast : '0;
         else           y_d = y_q - YW'(1);
      end
      // Pulse only on a real change, so clamped or cancelled steps stay silent.
      moved_d = (x_d != x_q) || (y_d != y_q);
   end

   // Cursor and moved registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         x_q     <= '0;
         y_q     <= '0;
         moved_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         y_q     <= y_d;
         moved_q <= moved_d;
      end
   end

   // Drive outputs straight from registers.
   always_comb begin
      cursor_x = x_q;
      cursor_y = y_q;
      moved    = moved_q;
   end

endmodule

// File: tb/tb_cursor_ctrl.sv
// tb_cursor_ctrl: directed and randomised checks of cursor_ctrl against a
// cycle-level behavioural model (timeline of raw samples and hold times).
module tb_cursor_ctrl;

   localparam int unsigned MX = 8;
   localparam int unsigned MY = 8;
   localparam int unsigned DB = 4;
   localparam int unsigned RD = 16;
   localparam int unsigned RR = 4;

`ifdef CURSOR_AUTOREPEAT_EN
   localparam bit AutoRep = 1'b1;
`else
   localparam bit AutoRep = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] move = 4'hF;
   logic       wrap_en = 1'b1;
   logic [7:0] cursor_x;
   logic [7:0] cursor_y;
   logic       moved;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   cursor_ctrl #(
      .MAX_X       (MX),
      .MAX_Y       (MY),
      .XW          (8),
      .YW          (8),
      .DEBOUNCE_CYC(DB),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .move    (move),
      .wrap_en (wrap_en),
      .cursor_x(cursor_x),
      .cursor_y(cursor_y),
      .moved   (moved)
   );

   // Reference model state.
   logic [3:0] raw_hist[$];
   logic [3:0] m_deb;
   logic [3:0] m_deb_prev;
   int         m_x;
   int         m_y;
   logic       m_moved;
   bit         m_active;
   int         m_t;

   task automatic model_reset();
      raw_hist.delete();
      for (int i = 0; i < int'(DB) + 3; i++) raw_hist.push_back(4'hF);
      m_deb      = 4'hF;
      m_deb_prev = 4'hF;
      m_x        = 0;
      m_y        = 0;
      m_moved    = 1'b0;
      m_active   = 1'b0;
      m_t        = 0;
   endtask

   // Advance the model by one clock edge with the given raw buttons and wrap mode.
   task automatic model_edge(input logic [3:0] raw, input logic wrap);
      logic [3:0] press, held, stp, deb_new;
      int         nx, ny;
      bit         all_flip;
      press = m_deb_prev & ~m_deb;
      held  = ~m_deb;
      stp   = 4'h0;
      if (AutoRep) begin
         // Steps at hold time 0, RD, RD+RR, RD+2*RR ... since the latest press.
         if (press != 4'h0) begin
            stp      = press;
            m_active = 1'b1;
            m_t      = 0;
         end else if (m_active && held == 4'h0) begin
            m_active = 1'b0;
         end else if (m_active) begin
            m_t++;
            if (m_t == int'(RD) || (m_t > int'(RD) && ((m_t - int'(RD)) % int'(RR)) == 0))
               stp = held;
         end
      end else begin
         stp = press;
      end
      nx = m_x + int'(stp[3]) - int'(stp[0]);
      ny = m_y + int'(stp[1]) - int'(stp[2]);
      if (wrap) begin
         nx = (nx + int'(MX)) % int'(MX);
         ny = (ny + int'(MY)) % int'(MY);
      end else begin
         if (nx < 0) nx = 0;
         if (nx > int'(MX) - 1) nx = int'(MX) - 1;
         if (ny < 0) ny = 0;
         if (ny > int'(MY) - 1) ny = int'(MY) - 1;
      end
      m_moved = (nx != m_x) || (ny != m_y);
      m_x = nx;
      m_y = ny;
      // A debounced bit flips once the last DB synchronised samples (raw from
      // two edges back and earlier) all disagree with it.
      raw_hist.push_back(raw);
      deb_new = m_deb;
      for (int b = 0; b < 4; b++) begin
         all_flip = 1'b1;
         for (int k = 0; k < int'(DB); k++) begin
            if (raw_hist[raw_hist.size() - 3 - k][b] == m_deb[b]) all_flip = 1'b0;
         end
         if (all_flip) deb_new[b] = ~m_deb[b];
      end
      m_deb_prev = m_deb;
      m_deb      = deb_new;
      void'(raw_hist.pop_front());
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
      end
   endtask

   // One clock with the given buttons, then compare all outputs with the model.
   task automatic cyc(input logic [3:0] m);
      move = m;
      @(posedge clk);
      model_edge(m, wrap_en);
      #1;
      check("cursor_x", {24'd0, cursor_x}, m_x);
      check("cursor_y", {24'd0, cursor_y}, m_y);
      check("moved", {31'd0, moved}, {31'd0, m_moved});
   endtask

   task automatic do_reset();
      rst = 1'b0;
      #1;
      check("rst_async_x", {24'd0, cursor_x}, 0);
      check("rst_async_y", {24'd0, cursor_y}, 0);
      check("rst_async_moved", {31'd0, moved}, 0);
      @(posedge clk);
      @(posedge clk);
      #1;
      check("rst_hold_x", {24'd0, cursor_x}, 0);
      check("rst_hold_moved", {31'd0, moved}, 0);
      rst = 1'b1;
      model_reset();
   endtask

   initial begin
      model_reset();
      move    = 4'hF;
      wrap_en = 1'b1;
      do_reset();

      // 1: single-cycle low is ignored; a held press lands exactly 7 edges later.
      cyc(4'b0111);
      repeat (10) cyc(4'hF);
      for (int i = 1; i <= 10; i++) begin
         cyc(4'b0111);
         if (i == 6) check("t1_x_before", {24'd0, cursor_x}, 0);
         if (i == 7) begin
            check("t1_x_step", {24'd0, cursor_x}, 1);
            check("t1_moved", {31'd0, moved}, 1);
         end
      end
      repeat (10) cyc(4'hF);

      // 2: glitchy press does not step; a steady press wraps 0 -> 7.
      do_reset();
      wrap_en = 1'b1;
      repeat (3) cyc(4'b1110);
      cyc(4'hF);
      repeat (3) cyc(4'b1110);
      check("t2_glitch_x", {24'd0, cursor_x}, 0);
      repeat (8) cyc(4'b1110);
      check("t2_wrap_x", {24'd0, cursor_x}, 7);
      repeat (10) cyc(4'hF);

      // 3: clamping at both corners.
      do_reset();
      wrap_en = 1'b0;
      repeat (10) cyc(4'b1010);
      repeat (10) cyc(4'hF);
      check("t3_clamp_lo_x", {24'd0, cursor_x}, 0);
      check("t3_clamp_lo_y", {24'd0, cursor_y}, 0);
      wrap_en = 1'b1;
      repeat (10) cyc(4'b1010);
      repeat (10) cyc(4'hF);
      check("t3_diag_x", {24'd0, cursor_x}, 7);
      check("t3_diag_y", {24'd0, cursor_y}, 7);
      wrap_en = 1'b0;
      repeat (10) cyc(4'b0101);
      repeat (10) cyc(4'hF);
      check("t3_clamp_hi_x", {24'd0, cursor_x}, 7);
      check("t3_clamp_hi_y", {24'd0, cursor_y}, 7);

      // 4: opposite x buttons cancel; adding y+1 moves only y (wraps to 0).
      wrap_en = 1'b1;
      repeat (10) cyc(4'b0110);
      check("t4_cancel_x", {24'd0, cursor_x}, 7);
      repeat (10) cyc(4'b0100);
      check("t4_add_x", {24'd0, cursor_x}, 7);
      check("t4_add_y", {24'd0, cursor_y}, 0);
      repeat (10) cyc(4'hF);

      // 5: long hold of y+1.
      do_reset();
      wrap_en = 1'b1;
      repeat (40) cyc(4'b1101);
      repeat (12) cyc(4'hF);
      check("t5_hold_y", {24'd0, cursor_y}, AutoRep ? 7 : 1);

      // 6: reset while holding x+1, then the held button counts as a new press.
      do_reset();
      repeat (30) cyc(4'b0111);
      do_reset();
      for (int i = 1; i <= 7; i++) begin
         cyc(4'b0111);
         if (i == 6) check("t6_x_before", {24'd0, cursor_x}, 0);
         if (i == 7) check("t6_x_step", {24'd0, cursor_x}, 1);
      end
      repeat (10) cyc(4'hF);

      // Random bursts of button patterns, wrap modes and occasional resets.
      for (int burst = 0; burst < 60; burst++) begin
         logic [3:0] pat;
         int         len;
         if ($urandom_range(0, 15) == 0) do_reset();
         pat     = 4'($urandom_range(0, 15));
         len     = int'($urandom_range(1, 30));
         wrap_en = 1'($urandom_range(0, 1));
         for (int j = 0; j < len; j++) cyc(pat);
      end
      repeat (12) cyc(4'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
